// File: rtl/comar_sched_pkg.sv
// ----------------------------------------------------------------------------
// comar_sched_pkg
// Shared constants, FSM state encoding and randomness-split helpers for the
// COMAR masked-XOR gadget scheduler (comar_xor_sched).
//   SHARE_W    : width of one share pair driven to the gadget
//   RND_W      : width of one fresh randomness word
//   RHI_W      : randomness bits held back for gadget stage 1
//   GADGET_LAT : register stages inside the shared gadget
// ----------------------------------------------------------------------------
package comar_sched_pkg;

    localparam int SHARE_W    = 2;
    localparam int RND_W      = 6;
    localparam int RHI_W      = RND_W - SHARE_W;
    localparam int GADGET_LAT = 2;

    // Scheduler FSM state; plain constants keep the encoding visible in waves
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

    // Mask bits consumed by gadget stage 0 in the issue cycle
    function automatic logic [SHARE_W-1:0] rnd_lo(input logic [RND_W-1:0] w);
        return w[SHARE_W-1:0];
    endfunction

    // Mask bits consumed by gadget stage 1, one cycle after issue
    function automatic logic [RHI_W-1:0] rnd_hi(input logic [RND_W-1:0] w);
        return w[RND_W-1:SHARE_W];
    endfunction

endpackage : comar_sched_pkg

// File: rtl/comar_rr_arbiter.sv
// ----------------------------------------------------------------------------
// comar_rr_arbiter
// Round-robin pick of one requester. The search starts at ptr_i+1 (modulo
// NUM_REQ), so the requester granted last has the lowest priority next time.
// Ports:
//   req_i  [NUM_REQ] in  : per-requester request
//   ptr_i  [ID_W]    in  : index of the most recently granted requester
//   en_i             in  : 0 forces an all-zero grant
//   gnt_o  [NUM_REQ] out : one-hot grant (or zero)
//   idx_o  [ID_W]    out : index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module comar_rr_arbiter
    import comar_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] cand_s;
    logic            found_s;
    logic            hit_s;

    // Walk the requesters in rotated order; the first hit wins and masks the rest
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s        = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            hit_s         = en_i & ~found_s & req_i[cand_s];
            gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
            idx_o         = hit_s ? cand_s : idx_o;
            found_s       = found_s | hit_s;
        end
    end

endmodule : comar_rr_arbiter

// File: rtl/comar_xor_sched.sv
// ----------------------------------------------------------------------------
// comar_xor_sched
// Shares one 2-stage COMAR masked-XOR gadget among NUM_REQ requesters.
// At most one op is issued per cycle (round-robin), each op consumes one fresh
// 6-bit randomness word, and the gadget result comes back two cycles after
// issue tagged with the requester ID.
//
// Build option (macro COMAR_SCHED_ZEROIZE_EN):
//   defined   : g_a_o, g_b_o and g_r_o[1:0] are forced to 0 in cycles without
//               issue, and the held-back mask bits are cleared one cycle after
//               their use, so stale shares/masks never toggle the gadget.
//   undefined : the gadget inputs keep the last issued values.
//   Response behaviour is identical in both builds.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   en_i                : 1 accept new requests, 0 drain in-flight ops then idle
//   req_valid_i/ready_o : per-requester handshake; ready is one-hot or zero
//   req_a_i, req_b_i    : share pairs, requester i at [2i+1:2i]
//   rnd_data_i/valid_i  : fresh randomness word; rnd_ready_o pulses on issue
//   g_a_o, g_b_o, g_r_o : operands and masks to the gadget
//   g_c_i               : gadget result
//   rsp_valid_o/id_o/c_o: single-cycle result, no backpressure
//   idle_o              : FSM idle and nothing in flight
// ----------------------------------------------------------------------------
module comar_xor_sched
    import comar_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [SHARE_W*NUM_REQ-1:0] req_a_i,
    input  logic [SHARE_W*NUM_REQ-1:0] req_b_i,
    input  logic [RND_W-1:0]           rnd_data_i,
    input  logic                       rnd_valid_i,
    output logic                       rnd_ready_o,
    output logic [SHARE_W-1:0]         g_a_o,
    output logic [SHARE_W-1:0]         g_b_o,
    output logic [RND_W-1:0]           g_r_o,
    input  logic [SHARE_W-1:0]         g_c_i,
    output logic                       rsp_valid_o,
    output logic [ID_W-1:0]            rsp_id_o,
    output logic [SHARE_W-1:0]         rsp_c_o,
    output logic                       idle_o
);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [RHI_W-1:0]        r_hi_q, r_hi_d;
    logic [GADGET_LAT-1:0]   vld_q, vld_d;
    logic [ID_W-1:0]         id_q [GADGET_LAT];
    logic [ID_W-1:0]         id_d [GADGET_LAT];

    logic                    arb_en_s;
    logic                    issue_s;
    logic [NUM_REQ-1:0]      gnt_s;
    logic [ID_W-1:0]         idx_s;
    logic [SHARE_W-1:0]      sel_a_s;
    logic [SHARE_W-1:0]      sel_b_s;
    logic [SHARE_W-1:0]      r_lo_s;

`ifndef COMAR_SCHED_ZEROIZE_EN
    logic [SHARE_W-1:0]      a_hold_q, a_hold_d;
    logic [SHARE_W-1:0]      b_hold_q, b_hold_d;
    logic [SHARE_W-1:0]      rlo_hold_q, rlo_hold_d;
`endif

    // Issue needs RUN, enable and a fresh mask word; the arbiter adds |req
    assign arb_en_s = (state_q == RUN) & en_i & rnd_valid_i;
    assign issue_s  = arb_en_s & (|req_valid_i);

    comar_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (arb_en_s),
        .gnt_o   (gnt_s),
        .idx_o   (idx_s)
    );

    assign req_ready_o = gnt_s;
    assign rnd_ready_o = issue_s;

    // One-hot AND-OR mux of the granted requester's share pairs
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = sel_a_s | (req_a_i[SHARE_W*i +: SHARE_W] & {SHARE_W{gnt_s[i]}});
            sel_b_s = sel_b_s | (req_b_i[SHARE_W*i +: SHARE_W] & {SHARE_W{gnt_s[i]}});
        end
    end

    // Gadget operand drive: live values on issue, zero or held values otherwise
    always_comb begin
`ifdef COMAR_SCHED_ZEROIZE_EN
        g_a_o  = issue_s ? sel_a_s : {SHARE_W{1'b0}};
        g_b_o  = issue_s ? sel_b_s : {SHARE_W{1'b0}};
        r_lo_s = issue_s ? rnd_lo(rnd_data_i) : {SHARE_W{1'b0}};
`else
        g_a_o  = issue_s ? sel_a_s : a_hold_q;
        g_b_o  = issue_s ? sel_b_s : b_hold_q;
        r_lo_s = issue_s ? rnd_lo(rnd_data_i) : rlo_hold_q;
`endif
        // r_hi was captured at issue, so it meets the op in gadget stage 1
        g_r_o  = {r_hi_q, r_lo_s};
    end

    // Next-state for FSM, pointer, held-back mask and in-flight tracker
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = en_i ? RUN : IDLE;
            RUN:     state_d = en_i ? RUN : DRAIN;
            DRAIN: begin
                if (en_i) begin
                    state_d = RUN;
                end else if (vld_q == {GADGET_LAT{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        ptr_d = issue_s ? idx_s : ptr_q;

`ifdef COMAR_SCHED_ZEROIZE_EN
        // Without a new issue the stored mask has just been used: clear it
        r_hi_d = issue_s ? rnd_hi(rnd_data_i) : {RHI_W{1'b0}};
`else
        r_hi_d = issue_s ? rnd_hi(rnd_data_i) : r_hi_q;
`endif

        vld_d    = {vld_q[GADGET_LAT-2:0], issue_s};
        id_d[0]  = issue_s ? idx_s : {ID_W{1'b0}};
        for (int s = 1; s < GADGET_LAT; s++) begin
            id_d[s] = id_q[s-1];
        end
    end

`ifndef COMAR_SCHED_ZEROIZE_EN
    // Remember the last issued operands so the gadget inputs stay quiet
    always_comb begin
        a_hold_d   = issue_s ? sel_a_s : a_hold_q;
        b_hold_d   = issue_s ? sel_b_s : b_hold_q;
        rlo_hold_d = issue_s ? rnd_lo(rnd_data_i) : rlo_hold_q;
    end

    // Operand hold registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_hold_q   <= {SHARE_W{1'b0}};
            b_hold_q   <= {SHARE_W{1'b0}};
            rlo_hold_q <= {SHARE_W{1'b0}};
        end else begin
            a_hold_q   <= a_hold_d;
            b_hold_q   <= b_hold_d;
            rlo_hold_q <= rlo_hold_d;
        end
    end
`endif

    // Scheduler state registers; reset drops every in-flight op
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            r_hi_q  <= {RHI_W{1'b0}};
            vld_q   <= {GADGET_LAT{1'b0}};
            for (int s = 0; s < GADGET_LAT; s++) begin
                id_q[s] <= {ID_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            r_hi_q  <= r_hi_d;
            vld_q   <= vld_d;
            for (int s = 0; s < GADGET_LAT; s++) begin
                id_q[s] <= id_d[s];
            end
        end
    end

    // The gadget's own output register provides the result timing
    assign rsp_valid_o = vld_q[GADGET_LAT-1];
    assign rsp_id_o    = id_q[GADGET_LAT-1];
    assign rsp_c_o     = g_c_i;
    assign idle_o      = (state_q == IDLE) & (vld_q == {GADGET_LAT{1'b0}});

endmodule : comar_xor_sched

// File: tb/tb_comar_xor_sched.sv
// ----------------------------------------------------------------------------
// tb_comar_xor_sched
// Directed bench for comar_xor_sched with a behavioural 2-stage masked-XOR
// gadget. Expected responses are pushed to a scoreboard queue when an issue is
// predicted and popped when their response cycle comes around.
// ----------------------------------------------------------------------------
module tb_comar_xor_sched;
    import comar_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic       clk = 1'b0;
    logic       rst, en, rnd_valid, rnd_ready, rsp_valid, idle;
    logic [3:0] req_valid, req_ready;
    logic [7:0] req_a, req_b;
    logic [5:0] rnd_data, g_r;
    logic [1:0] g_a, g_b, g_c, rsp_c, rsp_id;
    logic [1:0] gs1, gc;

    always #5 clk = ~clk;

    comar_xor_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rnd_data_i  (rnd_data),
        .rnd_valid_i (rnd_valid),
        .rnd_ready_o (rnd_ready),
        .g_a_o       (g_a),
        .g_b_o       (g_b),
        .g_r_o       (g_r),
        .g_c_i       (g_c),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_c_o     (rsp_c),
        .idle_o      (idle)
    );

    // Behavioural gadget: stage 0 uses g_r[1:0], stage 1 uses g_r[5:2]
    always @(posedge clk) begin
        gs1 <= g_a ^ g_b ^ {2{^g_r[1:0]}};
        gc  <= gs1 ^ {2{^g_r[5:2]}};
    end
    assign g_c = gc;

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [1:0] c;
    } exp_t;
    exp_t sbq[$];

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    state_t     m_state;
    logic [1:0] m_ptr, m_last_a, m_last_b, m_last_rlo;
    logic [3:0] m_last_rhi;
    logic       m_prev_issue;
    logic       e_issue, e_busy;
    logic [1:0] e_idx, ea, eb;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: check outputs before the edge, then advance the model
    task automatic cycle();
        logic [3:0] e_gnt;
        logic [1:0] ec, erlo, erhi;
        logic [3:0] rhi_exp;
        exp_t       ent;
        #1;
        if (!rst) begin
            e_busy = 1'b0;
            foreach (sbq[i]) if (sbq[i].due <= cyc + 1) e_busy = 1'b1;
            e_issue = (m_state == RUN) && en && rnd_valid && (req_valid != 4'd0);
            e_gnt   = 4'd0;
            e_idx   = 2'd0;
            if (e_issue) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (int'(m_ptr) + k) % NUM_REQ;
                    if (e_gnt == 4'd0 && req_valid[c]) begin
                        e_gnt[c] = 1'b1;
                        e_idx    = 2'(c);
                    end
                end
            end
            chk("req_ready", {4'd0, req_ready}, {4'd0, e_gnt});
            chk("rnd_ready", {7'd0, rnd_ready}, {7'd0, e_issue});
            chk("idle", {7'd0, idle}, {7'd0, (m_state == IDLE) && !e_busy});
            if (e_issue) begin
                ea   = req_a[2*e_idx +: 2];
                eb   = req_b[2*e_idx +: 2];
                erlo = rnd_data[1:0];
                chk("g_a", {6'd0, g_a}, {6'd0, ea});
                chk("g_b", {6'd0, g_b}, {6'd0, eb});
                chk("g_r_lo", {6'd0, g_r[1:0]}, {6'd0, erlo});
                ec = ea ^ eb ^ {2{^rnd_data[1:0]}} ^ {2{^rnd_data[5:2]}};
                ent.due = cyc + 2;
                ent.id  = e_idx;
                ent.c   = ec;
                sbq.push_back(ent);
            end else begin
`ifdef COMAR_SCHED_ZEROIZE_EN
                chk("g_a_zero", {6'd0, g_a}, 8'd0);
                chk("g_b_zero", {6'd0, g_b}, 8'd0);
                chk("g_r_lo_zero", {6'd0, g_r[1:0]}, 8'd0);
`else
                chk("g_a_hold", {6'd0, g_a}, {6'd0, m_last_a});
                chk("g_b_hold", {6'd0, g_b}, {6'd0, m_last_b});
                chk("g_r_lo_hold", {6'd0, g_r[1:0]}, {6'd0, m_last_rlo});
`endif
            end
`ifdef COMAR_SCHED_ZEROIZE_EN
            rhi_exp = m_prev_issue ? m_last_rhi : 4'd0;
`else
            rhi_exp = m_last_rhi;
`endif
            chk("g_r_hi", {4'd0, g_r[5:2]}, {4'd0, rhi_exp});
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                ent = sbq.pop_front();
                chk("rsp_valid", {7'd0, rsp_valid}, 8'd1);
                chk("rsp_id", {6'd0, rsp_id}, {6'd0, ent.id});
                chk("rsp_c", {6'd0, rsp_c}, {6'd0, ent.c});
                chk("rsp_xor", {7'd0, ^rsp_c}, {7'd0, ^ent.c});
            end else begin
                chk("rsp_valid_idle", {7'd0, rsp_valid}, 8'd0);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_state      = IDLE;
            m_ptr        = 2'd3;
            m_last_a     = 2'd0;
            m_last_b     = 2'd0;
            m_last_rlo   = 2'd0;
            m_last_rhi   = 4'd0;
            m_prev_issue = 1'b0;
            sbq.delete();
        end else begin
            if (e_issue) begin
                m_ptr      = e_idx;
                m_last_a   = ea;
                m_last_b   = eb;
                m_last_rlo = rnd_data[1:0];
                m_last_rhi = rnd_data[5:2];
            end
            m_prev_issue = e_issue;
            case (m_state)
                IDLE:    m_state = en ? RUN : IDLE;
                RUN:     m_state = en ? RUN : DRAIN;
                DRAIN:   m_state = en ? RUN : (e_busy ? DRAIN : IDLE);
                default: m_state = IDLE;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        // 1: reset with every input active
        rst = 1'b1; en = 1'b1; req_valid = 4'hF; req_a = 8'hFF; req_b = 8'hFF;
        rnd_data = 6'h3F; rnd_valid = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();                      // IDLE after reset: no grant, idle=1

        // 2: single request from requester 0
        req_valid = 4'b0001; req_a = 8'b0000_0010; req_b = 8'b0000_0011; rnd_data = 6'h2A;
        cycle();
        chk("t2_rhi_direct", {4'd0, g_r[5:2]}, 8'h0A);
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) cycle();

        // 3: all requesters held valid, fresh word every cycle
        req_valid = 4'hF; req_a = 8'b1110_0100; req_b = 8'b0110_1100;
        for (int i = 0; i < 8; i++) begin
            rnd_data = 6'(i * 7 + 5);
            cycle();
        end

        // 4: randomness gap of 3 cycles mid-stream
        for (int i = 0; i < 7; i++) begin
            rnd_valid = (i < 2 || i > 4);
            rnd_data  = 6'($urandom_range(0, 63));
            req_a     = 8'($urandom_range(0, 255));
            req_b     = 8'($urandom_range(0, 255));
            cycle();
        end

        // 5: two issues then en falls while requests are still valid
        rnd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rnd_data = 6'(17 + i * 9);
            cycle();
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // back to RUN, then DRAIN -> RUN with one low-enable cycle
        en = 1'b1;
        cycle();
        for (int i = 0; i < 2; i++) begin rnd_data = 6'(40 + i); cycle(); end
        en = 1'b0;
        cycle();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin rnd_data = 6'(50 + i); cycle(); end

        // single requester continuously valid
        req_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin rnd_data = 6'(i * 11); cycle(); end

        // 6: reset right after an issue drops the in-flight op
        req_valid = 4'b0010; rnd_data = 6'h15;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("t6_idle", {7'd0, idle}, 8'd1);
        chk("t6_rsp_valid", {7'd0, rsp_valid}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_comar_xor_sched
